// File: rtl/hamming_pkg.sv
// Shared Hamming (7,4) definitions: codeword bit positions, receiver FSM states, syndrome function.
// Define HAMMING_SECDED_EN to add an overall parity bit cw[7] (SECDED, 8-bit codewords).
package hamming_pkg;

`ifdef HAMMING_SECDED_EN
  localparam int unsigned CW_W = 8;
  localparam int unsigned PosP8 = 7;
`else
  localparam int unsigned CW_W = 7;
`endif

  // Bit index in cw for Hamming positions 1..7
  localparam int unsigned PosP1 = 0;
  localparam int unsigned PosP2 = 1;
  localparam int unsigned PosD1 = 2;
  localparam int unsigned PosP4 = 3;
  localparam int unsigned PosD2 = 4;
  localparam int unsigned PosD3 = 5;
  localparam int unsigned PosD4 = 6;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

  function automatic logic [2:0] hamming_syndrome(input logic [6:0] cw);
    logic s1, s2, s4;
    s1 = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    s2 = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    s4 = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    return {s4, s2, s1};
  endfunction

endpackage

// File: rtl/hamming_dec_core.sv
// Combinational Hamming (7,4) syndrome, single-bit correction and data extraction.
// With HAMMING_SECDED_EN, overall parity in cw[7] also flags uncorrectable double errors.
module hamming_dec_core
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0] cw_i,
  output logic [3:0]      data_o,
  output logic [2:0]      syndrome_o,
  output logic            corrected_o,
  output logic            dbl_err_o
);

  logic [7:0] flip_mask;
  logic [6:0] fixed;
`ifdef HAMMING_SECDED_EN
  logic       parity_err;
`endif

  always_comb begin
    syndrome_o  = hamming_syndrome(cw_i[6:0]);
    corrected_o = (syndrome_o != 3'd0);
    dbl_err_o   = 1'b0;
`ifdef HAMMING_SECDED_EN
    parity_err = ^cw_i;
    if (corrected_o && !parity_err) begin
      dbl_err_o   = 1'b1;
      corrected_o = 1'b0;
    end else if (!corrected_o && parity_err) begin
      corrected_o = 1'b1;
    end
`endif
    // Syndrome value is the 1-based position of the bad bit; bit 0 of the mask is never used
    flip_mask = 8'd1 << syndrome_o;
    fixed     = dbl_err_o ? cw_i[6:0] : (cw_i[6:0] ^ flip_mask[7:1]);
    data_o    = {fixed[PosD4], fixed[PosD3], fixed[PosD2], fixed[PosD1]};
  end

endmodule

// File: rtl/hamming_serial_rx.sv
// Serial (start, code bits LSB first, stop) receiver feeding a Hamming decoder and a one-entry
// valid/ready holding register. HAMMING_SECDED_EN selects 8-bit SECDED frames.
module hamming_serial_rx
  import hamming_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_serial,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [3:0]       m_data,
  output logic             m_corrected,
  output logic [2:0]       m_syndrome,
  output logic             m_dbl_err,
  output logic             frame_err,
  output logic             overrun,
  output logic [CNT_W-1:0] corr_count
);

  localparam int unsigned TickW = $clog2(CLKS_PER_BIT);
  localparam logic [TickW-1:0] TickLast = TickW'(CLKS_PER_BIT - 1);
  localparam logic [TickW-1:0] TickHalf = TickW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0] BitLast = 4'(CW_W - 1);

  logic [1:0]       sync_q, sync_d;
  rx_state_e        state_q, state_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [3:0]       bit_q, bit_d;
  logic [CW_W-1:0]  cw_q, cw_d;
  logic             valid_q, valid_d;
  logic [3:0]       data_q, data_d;
  logic             corr_q, corr_d;
  logic [2:0]       synd_q, synd_d;
  logic             dbl_q, dbl_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       rx_s, frame_done, frame_bad, load;
  logic [3:0] dec_data;
  logic [2:0] dec_synd;
  logic       dec_corr, dec_dbl;

  assign rx_s   = sync_q[1];
  assign sync_d = {sync_q[0], rx_serial};

  hamming_dec_core u_dec (
    .cw_i        (cw_q),
    .data_o      (dec_data),
    .syndrome_o  (dec_synd),
    .corrected_o (dec_corr),
    .dbl_err_o   (dec_dbl)
  );

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    cw_d       = cw_q;
    frame_done = 1'b0;
    frame_bad  = 1'b0;
    case (state_q)
      StIdle: begin
        tick_d = '0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (tick_q == TickHalf) begin
          tick_d  = '0;
          bit_d   = '0;
          // A line that is high again at mid start bit was only a glitch
          state_d = rx_s ? StIdle : StData;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StData: begin
        if (tick_q == TickLast) begin
          tick_d = '0;
          cw_d   = {rx_s, cw_q[CW_W-1:1]};
          bit_d  = bit_q + 4'd1;
          if (bit_q == BitLast) state_d = StStop;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StStop: begin
        if (tick_q == TickLast) begin
          tick_d     = '0;
          state_d    = StIdle;
          frame_done = rx_s;
          frame_bad  = !rx_s;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    load        = frame_done && (!valid_q || m_ready);
    overrun_d   = frame_done && valid_q && !m_ready;
    frame_err_d = frame_bad;
    valid_d     = load ? 1'b1 : (m_ready ? 1'b0 : valid_q);
    data_d      = load ? dec_data : data_q;
    corr_d      = load ? dec_corr : corr_q;
    synd_d      = load ? dec_synd : synd_q;
    dbl_d       = load ? dec_dbl : dbl_q;
    count_d     = count_q;
    if (load && dec_corr && (count_q != {CNT_W{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;
      state_q     <= StIdle;
      tick_q      <= '0;
      bit_q       <= '0;
      cw_q        <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      corr_q      <= 1'b0;
      synd_q      <= '0;
      dbl_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      cw_q        <= cw_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      corr_q      <= corr_d;
      synd_q      <= synd_d;
      dbl_q       <= dbl_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      count_q     <= count_d;
    end
  end

  assign m_valid     = valid_q;
  assign m_data      = data_q;
  assign m_corrected = corr_q;
  assign m_syndrome  = synd_q;
  assign m_dbl_err   = dbl_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
  assign corr_count  = count_q;

endmodule
